bus_master_if: RTL and testbench

- Bus initiator sitting between a CPU pipeline stage (fetch or memory access) and the shared system bus.
- Converts a one-cycle CPU access request into an arbitrated bus transaction: request, wait for grant, strobe address, wait for slave ready.
- Returns read data to the stage and stalls the pipeline until the transaction completes.
- It is the counterpart of the bus slaves (ROM, RAM, peripherals), which drive rdy_ one cycle after cs_/as_.

---
 rtl/bus_master_if_pkg.sv | 22 ++
 rtl/bus_master_if_timer.sv | 28 ++
 rtl/bus_master_if.sv | 113 +++++++++++
 tb/tb_bus_master_if.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the bus initiator: state encoding, direction and
// active-low strobe levels, and default bus widths.
package bus_master_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Bus strobes, request and ready are all active-low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int DEFAULT_ADDR_W = 30;
  localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/bus_master_if_timer.sv
// Ready-wait watchdog for bus_master_if: counts stalled ACCESS cycles and
// flags the cycle in which the wait reaches TIMEOUT_CYC.
module bus_master_if_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] count;

  // The terminal cycle is the one whose increment would reach TIMEOUT_CYC.
  assign hit = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_master_if.sv
// Bus initiator turning one-cycle CPU accesses into arbitrated bus transactions.
// Define BUS_MASTER_IF_TIMEOUT_EN to abort ready-waits after TIMEOUT_CYC cycles.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              cpu_as_,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              busy,
  output logic              err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  state_t state;
  logic   timeout_hit;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
  bus_master_if_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state != ACCESS),
    .enable(state == ACCESS && bus_rdy_ == DISABLE_),
    .hit   (timeout_hit)
  );
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      cpu_rd_data <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_as_ == ENABLE_ && !flush) begin
            bus_addr    <= cpu_addr;
            bus_rw      <= cpu_rw;
            bus_wr_data <= cpu_wr_data;
            bus_req_    <= ENABLE_;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus_grnt_ == ENABLE_) begin
            bus_as_ <= ENABLE_;
            state   <= ACCESS;
          end
        end
        // Address strobe lasts one cycle; the request is held until ready.
        ACCESS: begin
          bus_as_ <= DISABLE_;
          if (bus_rdy_ == ENABLE_) begin
            bus_req_ <= DISABLE_;
            if (bus_rw == READ) begin
              cpu_rd_data <= bus_rd_data;
            end
            state <= stall ? STALL : IDLE;
          end else if (timeout_hit) begin
            bus_req_    <= DISABLE_;
            cpu_rd_data <= '0;
            err         <= 1'b1;
            state       <= stall ? STALL : IDLE;
          end
        end
        STALL: begin
          if (!stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      IDLE:    busy = (cpu_as_ == ENABLE_) && !flush;
      REQ:     busy = 1'b1;
      ACCESS:  busy = (bus_rdy_ == DISABLE_) && !timeout_hit;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: directed table, randomized
// transactions against a transaction-level model, and corner-case sequences.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  localparam int ADDR_W      = 30;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 4;
  localparam int MAX_CYC     = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              flush;
  logic              cpu_as_;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              busy;
  logic              err;
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  bus_master_if #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .cpu_as_    (cpu_as_),
    .cpu_rw     (cpu_rw),
    .cpu_addr   (cpu_addr),
    .cpu_wr_data(cpu_wr_data),
    .cpu_rd_data(cpu_rd_data),
    .busy       (busy),
    .err        (err),
    .bus_req_   (bus_req_),
    .bus_grnt_  (bus_grnt_),
    .bus_as_    (bus_as_),
    .bus_rw     (bus_rw),
    .bus_addr   (bus_addr),
    .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data),
    .bus_rdy_   (bus_rdy_)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                grant_wait;
    int                rdy_wait;
    int                stall_cyc;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  int                vectors;
  int                miscompares;
  logic [DATA_W-1:0] model_rd;
  vec_t              table_vec[5];

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic as_n, input logic rw,
                                input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata,
                                input logic fl, input logic st);
    cpu_as_     = as_n;
    cpu_rw      = rw;
    cpu_addr    = addr;
    cpu_wr_data = wdata;
    flush       = fl;
    stall       = st;
  endtask

  task automatic apply_junk(input logic st);
    apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ADDR_W'($urandom),
                   $urandom, 1'($urandom_range(0, 1)), st);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_bus_req_"}, bus_req_, 1'b1);
    check_output({tag, "_bus_as_"}, bus_as_, 1'b1);
    check_output({tag, "_bus_rw"}, bus_rw, 1'b1);
    check_output({tag, "_bus_addr"}, bus_addr, '0);
    check_output({tag, "_bus_wr_data"}, bus_wr_data, '0);
    check_output({tag, "_cpu_rd_data"}, cpu_rd_data, '0);
    check_output({tag, "_err"}, err, 1'b0);
    check_output({tag, "_busy"}, busy, 1'b0);
  endtask

  // One full transaction with a reactive slave. Expected timing: request at
  // cycle 1, strobe at grant_wait+2, ready at strobe+1+rdy_wait, so the CPU
  // sees busy for grant_wait+rdy_wait+3 cycles and bus_req_ for the same span.
  task automatic run_txn(input vec_t v, input string tag);
    int  busy_cnt    = 0;
    int  as_cnt      = 0;
    int  req_low_cnt = 0;
    int  strobe_cyc  = -1;
    int  cyc         = 1;
    bit  done        = 0;
    logic st         = (v.stall_cyc > 0);

    apply_stimulus(1'b0, v.rw, v.addr, v.wdata, 1'b0, st);
    bus_grnt_   = 1'b1;
    bus_rdy_    = 1'($urandom_range(0, 1));
    bus_rd_data = $urandom;
    #1;
    if (busy) busy_cnt++;
    next_cycle();

    while (!done && cyc < MAX_CYC) begin
      if (bus_req_ == 1'b0) req_low_cnt++;
      if (bus_as_ == 1'b0) begin
        as_cnt++;
        if (strobe_cyc < 0) begin
          strobe_cyc = cyc;
          check_output({tag, "_strobe_cycle"}, strobe_cyc, v.grant_wait + 2);
          check_output({tag, "_strobe_addr"}, bus_addr, v.addr);
          check_output({tag, "_strobe_rw"}, bus_rw, v.rw);
          check_output({tag, "_strobe_wdata"}, bus_wr_data, v.wdata);
        end
      end
      apply_junk(st);
      bus_rd_data = $urandom;
      if (strobe_cyc < 0) begin
        bus_grnt_ = (cyc >= v.grant_wait + 1) ? 1'b0 : 1'b1;
        bus_rdy_  = 1'($urandom_range(0, 1));
      end else begin
        bus_grnt_ = 1'($urandom_range(0, 1));
        bus_rdy_  = 1'b1;
        if (cyc == strobe_cyc + 1 + v.rdy_wait) begin
          bus_rdy_    = 1'b0;
          bus_rd_data = v.rdata;
          done        = 1;
          check_output({tag, "_held_addr"}, bus_addr, v.addr);
          check_output({tag, "_held_rw"}, bus_rw, v.rw);
        end
      end
      #1;
      if (busy) busy_cnt++;
      next_cycle();
      cyc++;
    end

    check_output({tag, "_completed"}, done, 1'b1);
    check_output({tag, "_as_pulses"}, as_cnt, 1);
    check_output({tag, "_busy_cycles"}, busy_cnt, v.grant_wait + v.rdy_wait + 3);
    check_output({tag, "_req_cycles"}, req_low_cnt, v.grant_wait + v.rdy_wait + 3);

    check_output({tag, "_post_req_"}, bus_req_, 1'b1);
    check_output({tag, "_post_as_"}, bus_as_, 1'b1);
    check_output({tag, "_rd_data"}, cpu_rd_data, v.exp_rd);
    check_output({tag, "_post_err"}, err, 1'b0);
    apply_stimulus(1'b1, READ, '0, '0, 1'b0, st);
    bus_grnt_ = 1'b1;
    bus_rdy_  = 1'($urandom_range(0, 1));
    #1;
    check_output({tag, "_post_busy"}, busy, 1'b0);
    model_rd = v.exp_rd;

    if (v.stall_cyc > 0) begin
      next_cycle();
      for (int i = 1; i < v.stall_cyc; i++) begin
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom,
                       1'($urandom_range(0, 1)), 1'b1);
        #1;
        check_output({tag, "_stall_busy"}, busy, 1'b0);
        check_output({tag, "_stall_req_"}, bus_req_, 1'b1);
        check_output({tag, "_stall_rd_data"}, cpu_rd_data, v.exp_rd);
        next_cycle();
      end
      apply_stimulus(1'b0, READ, ADDR_W'($urandom), $urandom, 1'b0, 1'b0);
      #1;
      check_output({tag, "_stall_exit_busy"}, busy, 1'b0);
    end
    next_cycle();
  endtask

  // Slave never answers: with the watchdog the access aborts after
  // TIMEOUT_CYC ACCESS cycles, otherwise it waits with busy held high.
  task automatic timeout_sequence();
    int strobe_cyc = -1;
    int err_cyc    = -1;
    int err_hi     = 0;
    int busy_hi    = 0;
    int access_cyc = 0;
    logic              req_at_err = 1'b0;
    logic [DATA_W-1:0] rd_at_err  = '1;

    apply_stimulus(1'b0, READ, ADDR_W'(32'h40), '0, 1'b0, 1'b0);
    bus_grnt_ = 1'b1;
    bus_rdy_  = 1'b1;
    #1;
    next_cycle();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (bus_as_ == 1'b0 && strobe_cyc < 0) strobe_cyc = cyc;
      if (err) begin
        err_hi++;
        if (err_cyc < 0) begin
          err_cyc    = cyc;
          req_at_err = bus_req_;
          rd_at_err  = cpu_rd_data;
        end
      end
      apply_stimulus(1'b1, READ, '0, '0, 1'b0, 1'b0);
      bus_grnt_   = (strobe_cyc < 0) ? 1'b0 : 1'b1;
      bus_rdy_    = 1'b1;
      bus_rd_data = $urandom;
      #1;
      if (strobe_cyc >= 0 && err_cyc < 0) begin
        access_cyc++;
        if (busy) busy_hi++;
      end
      next_cycle();
    end
    check_output("to_strobe_cycle", strobe_cyc, 2);
`ifdef BUS_MASTER_IF_TIMEOUT_EN
    check_output("to_err_delay", err_cyc - strobe_cyc, TIMEOUT_CYC);
    check_output("to_err_width", err_hi, 1);
    check_output("to_busy_cycles", busy_hi, TIMEOUT_CYC - 1);
    check_output("to_req_released", req_at_err, 1'b1);
    check_output("to_rd_cleared", rd_at_err, '0);
    model_rd = '0;
`else
    check_output("nto_err_never", err_hi, 0);
    check_output("nto_access_cycles", access_cyc, 19);
    check_output("nto_busy_cycles", busy_hi, 19);
    check_output("nto_req_held", bus_req_, 1'b0);
    bus_rdy_    = 1'b0;
    bus_rd_data = 32'h0BADCAFE;
    next_cycle();
    bus_rdy_ = 1'b1;
    check_output("nto_late_rd_data", cpu_rd_data, 32'h0BADCAFE);
    check_output("nto_late_req_", bus_req_, 1'b1);
    model_rd = 32'h0BADCAFE;
`endif
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    vectors     = 0;
    miscompares = 0;
    model_rd    = '0;

    table_vec[0] = '{READ,  ADDR_W'(32'h10), 32'h0,        32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF};
    table_vec[1] = '{WRITE, ADDR_W'(32'h20), 32'h12345678, 32'h55555555, 3, 0, 0, 32'hDEADBEEF};
    table_vec[2] = '{READ,  ADDR_W'(32'h30), 32'h0,        32'hCAFEF00D, 0, 0, 5, 32'hCAFEF00D};
    table_vec[3] = '{WRITE, '1,              32'hFFFFFFFF, 32'h77777777, 1, 2, 2, 32'hCAFEF00D};
    table_vec[4] = '{READ,  '0,              32'h0,        32'h00000001, 2, 3, 0, 32'h00000001};

    reset = 1'b0;
    apply_stimulus(1'b1, READ, '0, '0, 1'b0, 1'b0);
    bus_grnt_   = 1'b1;
    bus_rdy_    = 1'b1;
    bus_rd_data = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    next_cycle();

    apply_stimulus(1'b0, READ, ADDR_W'(32'h55), 32'h1, 1'b1, 1'b0);
    #1;
    check_output("flush_busy", busy, 1'b0);
    next_cycle();
    check_output("flush_req_", bus_req_, 1'b1);
    apply_stimulus(1'b1, READ, '0, '0, 1'b0, 1'b0);
    #1;
    check_output("flush_idle_busy", busy, 1'b0);
    next_cycle();

    for (int i = 0; i < 5; i++) begin
      run_txn(table_vec[i], $sformatf("tbl%0d", i));
    end

    apply_stimulus(1'b0, WRITE, ADDR_W'(32'h2AA), 32'hA5A5A5A5, 1'b0, 1'b0);
    bus_grnt_ = 1'b1;
    bus_rdy_  = 1'b1;
    #1;
    next_cycle();
    apply_stimulus(1'b1, READ, '0, '0, 1'b0, 1'b0);
    bus_grnt_ = 1'b0;
    #1;
    next_cycle();
    check_output("midrst_in_access", bus_as_, 1'b0);
    reset     = 1'b0;
    bus_grnt_ = 1'b1;
    #1;
    next_cycle();
    check_reset_state("midrst");
    reset    = 1'b1;
    model_rd = '0;
    next_cycle();

    for (int i = 0; i < 40; i++) begin
      v.rw         = 1'($urandom_range(0, 1));
      v.addr       = ADDR_W'($urandom);
      v.wdata      = $urandom;
      v.rdata      = $urandom;
      v.grant_wait = int'($urandom_range(0, 3));
      v.rdy_wait   = int'($urandom_range(0, 3));
      v.stall_cyc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      v.exp_rd     = (v.rw == READ) ? v.rdata : model_rd;
      run_txn(v, $sformatf("rnd%0d", i));
    end

    timeout_sequence();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
